div: RTL and testbench

- Iterative 32-bit integer divider for RISC-V M-extension DIV/DIVU/REM/REMU.
- The EX stage launches it with operands and consumes `{remainder, quotient}` when `ready_o` rises.
- While the divider is busy, EX raises its pipeline stall request.
- Restoring radix-2 algorithm: one quotient bit per cycle.

---
 rtl/div_pkg.sv | 25 ++
 rtl/div.sv | 146 ++++++++++++++
 tb/tb_div.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared types for the iterative integer divider.
//   div_state_e  - divider FSM state encoding
//   DIV_DATA_W   - operand width (only 32 supported)
//   mag32()      - magnitude of a 32-bit operand, signed or unsigned
package div_pkg;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_CNT_W  = 6;

    typedef enum logic [2:0] {
        DIV_FREE   = 3'd0,
        DIV_BYZERO = 3'd1,
        DIV_OVF    = 3'd2,
        DIV_ON     = 3'd3,
        DIV_END    = 3'd4,
        DIV_FAST   = 3'd5
    } div_state_e;

    // Two's-complement negate only when the operand is signed and negative.
    // 0x80000000 maps to itself, which reads correctly as an unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div.sv
// div: iterative restoring radix-2 divider for RISC-V DIV/DIVU/REM/REMU.
//   One quotient bit per cycle; operands latched at launch.
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   signed_div_i  1 = DIV/REM, 0 = DIVU/REMU
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       level request, held until the result is consumed
//   annul_i       cancel the in-flight operation
//   result_o      {remainder, quotient}, registered
//   ready_o       result valid, registered
//   busy_o        FSM not in DIV_FREE
// Build option: DIV_FAST_PATH_EN - when defined, |divisor| > |dividend|
//   finishes in two cycles with quotient 0, remainder = dividend.
module div
    import div_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int CNT_W  = DIV_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  busy_o
);

    div_state_e              state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [DATA_W-1:0]       dvd_q;   // dividend shifts out MSB-first, quotient shifts in
    logic [DATA_W-1:0]       dsr_q;
    logic [DATA_W-1:0]       rem_q;
    logic                    neg_quo_q;
    logic                    neg_rem_q;
    logic [2*DATA_W-1:0]     res_q;   // final result, presented from DIV_END

    logic [DATA_W-1:0]       mag1_d, mag2_d;
    logic                    ovf_d;
    logic [DATA_W:0]         shift_d, trial_d;
    logic                    qbit_d;
    logic [DATA_W-1:0]       rem_d, quo_d, rem_fix_d, quo_fix_d;

    assign mag1_d = mag32(opdata1_i, signed_div_i);
    assign mag2_d = mag32(opdata2_i, signed_div_i);
    assign ovf_d  = signed_div_i && (opdata1_i == {1'b1, {(DATA_W-1){1'b0}}}) && (&opdata2_i);

    // 33-bit trial subtract: borrow out (bit DATA_W) means the divisor did not fit.
    assign shift_d   = {rem_q, dvd_q[DATA_W-1]};
    assign trial_d   = shift_d - {1'b0, dsr_q};
    assign qbit_d    = ~trial_d[DATA_W];
    assign rem_d     = qbit_d ? trial_d[DATA_W-1:0] : shift_d[DATA_W-1:0];
    assign quo_d     = {dvd_q[DATA_W-2:0], qbit_d};
    assign quo_fix_d = neg_quo_q ? (~quo_d + 1'b1) : quo_d;
    assign rem_fix_d = neg_rem_q ? (~rem_d + 1'b1) : rem_d;

    assign busy_o = (state_q != DIV_FREE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DIV_FREE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            res_q     <= '0;
            result_o  <= '0;
            ready_o   <= 1'b0;
        end else begin
            case (state_q)
                DIV_FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        dvd_q     <= mag1_d;
                        dsr_q     <= mag2_d;
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        neg_quo_q <= signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        neg_rem_q <= signed_div_i && opdata1_i[DATA_W-1];
                        // Short paths preload res_q now; their state just waits a cycle.
                        if (opdata2_i == '0) begin
                            state_q <= DIV_BYZERO;
                            res_q   <= {opdata1_i, {DATA_W{1'b1}}};
                        end else if (ovf_d) begin
                            state_q <= DIV_OVF;
                            res_q   <= {{DATA_W{1'b0}}, 1'b1, {(DATA_W-1){1'b0}}};
                        end
`ifdef DIV_FAST_PATH_EN
                        else if (mag2_d > mag1_d) begin
                            state_q <= DIV_FAST;
                            res_q   <= {opdata1_i, {DATA_W{1'b0}}};
                        end
`endif
                        else begin
                            state_q <= DIV_ON;
                        end
                    end
                end
                DIV_BYZERO, DIV_OVF, DIV_FAST: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    state_q  <= annul_i ? DIV_FREE : DIV_END;
                end
                DIV_ON: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (annul_i) begin
                        state_q <= DIV_FREE;
                    end else begin
                        rem_q <= rem_d;
                        dvd_q <= quo_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(DATA_W-1)) begin
                            res_q   <= {rem_fix_d, quo_fix_d};
                            state_q <= DIV_END;
                        end
                    end
                end
                DIV_END: begin
                    if (annul_i || !start_i) begin
                        state_q  <= DIV_FREE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end else begin
                        ready_o  <= 1'b1;
                        result_o <= res_q;
                    end
                end
                default: begin
                    state_q  <= DIV_FREE;
                    ready_o  <= 1'b0;
                    result_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
module tb_div;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0, opdata2_i = '0;
    logic        start_i = 1'b0, annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o, busy_o;

    div dut (
        .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
        .start_i(start_i), .annul_i(annul_i),
        .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: RISC-V division semantics from plain arithmetic.
    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
        int sa, sb, q, r;
        logic [31:0] qq, rr;
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        if (s) begin
            sa = a; sb = b;
            q = sa / sb; r = sa % sb;
            qq = q; rr = r;
            return {rr, qq};
        end
        return {a % b, a / b};
    endfunction

    function automatic int ref_lat(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint ma, mb;
        if (b == 0) return 2;
        if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) return 2;
        ma = (s && a[31]) ? -longint'($signed(a)) : longint'(a);
        mb = (s && b[31]) ? -longint'($signed(b)) : longint'(b);
`ifdef DIV_FAST_PATH_EN
        if (mb > ma) return 2;
`endif
        if (mb > ma + 64'sd1 << 40) return 33; // never true; keeps ma/mb used in both builds
        return 33;
    endfunction

    // Monitor: compare each result on the rising edge of ready_o; also
    // checks result stability while ready is held and zero when it is low.
    logic        rdy_prev = 1'b0;
    logic [63:0] held = '0;
    always @(negedge clk) begin
        if (rst) begin
            if (ready_o && !rdy_prev) begin
                if (sb_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_ready: got result %h with no pending op", result_o);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("result", result_o, e.res);
                    check("latency_cycle", 64'(cyc), 64'(e.cyc));
                end
                held = result_o;
            end else if (ready_o) begin
                check("result_hold", result_o, held);
            end else begin
                check("result_idle_zero", result_o, 64'h0);
            end
        end
        rdy_prev = ready_o;
    end

    task automatic run_op(input bit s, input logic [31:0] a, input logic [31:0] b, input int hold);
        exp_t e;
        bit seen;
        @(negedge clk);
        signed_div_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
        e.res = ref_div(s, a, b);
        e.cyc = cyc + 1 + ref_lat(s, a, b);
        sb_q.push_back(e);
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == 0) begin
                // latched operands must not be affected
                opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = $urandom_range(0, 1);
            end
            if (ready_o) begin seen = 1; break; end
        end
        if (!seen) begin
            n_chk++; n_fail++;
            $display("FAIL ready_timeout: got ready_o=0 after 60 cycles, expected 1 (a=%h b=%h)", a, b);
            void'(sb_q.pop_front());
        end
        repeat (hold) @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        check("ready_clear", {63'h0, ready_o}, 64'h0);
        check("busy_clear", {63'h0, busy_o}, 64'h0);
    endtask

    initial begin
        #2;
        check("reset_result", result_o, 64'h0);
        check("reset_ready", {63'h0, ready_o}, 64'h0);
        check("reset_busy", {63'h0, busy_o}, 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_op(0, 32'd100, 32'd7, 1);
        run_op(1, 32'hFFFFFFF9, 32'h2, 0);
        run_op(1, 32'h7, 32'hFFFFFFFE, 2);
        run_op(1, 32'd5, 32'd0, 0);
        run_op(0, 32'd5, 32'd0, 0);
        run_op(1, 32'h80000000, 32'hFFFFFFFF, 0);
        run_op(0, 32'h80000000, 32'hFFFFFFFF, 0);
        run_op(1, 32'hFFFFFFFD, 32'd5, 0);
        run_op(0, 32'd3, 32'd1000, 0);
        run_op(0, 32'hFFFFFFFF, 32'h1, 5);

        // start together with annul must not launch
        @(negedge clk);
        opdata1_i = 32'd9; opdata2_i = 32'd3; signed_div_i = 0;
        start_i = 1'b1; annul_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; annul_i = 1'b0;
        check("start_annul_no_launch", {63'h0, busy_o}, 64'h0);

        // annul mid-iteration
        @(negedge clk);
        opdata1_i = 32'd1000; opdata2_i = 32'd7; start_i = 1'b1;
        repeat (11) @(negedge clk);
        check("busy_before_annul", {63'h0, busy_o}, 64'h1);
        annul_i = 1'b1; start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        check("annul_busy_drop", {63'h0, busy_o}, 64'h0);
        repeat (40) @(negedge clk);
        check("annul_no_ready", {63'h0, ready_o}, 64'h0);
        run_op(0, 32'd9, 32'd3, 0);

        // asynchronous reset mid-iteration
        @(negedge clk);
        opdata1_i = 32'd12345; opdata2_i = 32'd17; signed_div_i = 0; start_i = 1'b1;
        repeat (21) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_busy", {63'h0, busy_o}, 64'h0);
        check("rst_ready", {63'h0, ready_o}, 64'h0);
        check("rst_result", result_o, 64'h0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // randomized mix
        for (int k = 0; k < 40; k++) begin
            logic [31:0] a, b;
            bit s;
            s = $urandom_range(0, 1);
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = $urandom_range(1, 100);
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                3: b = a + $urandom_range(1, 50);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 1000);
            run_op(s, a, b, $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
